// File: rtl/serial_add_pkg.sv
// serial_add_pkg
// Shared constants and types for the serial adder controller:
//   WIDTH_DEFAULT - default operand/result width in bits
//   SLICE_BITS    - bits added per cycle by the adder slice
//   state_e       - controller state encoding (idle, run, done)
//   idx_width()   - width of the slice index counter for a given operand width
package serial_add_pkg;

   localparam int unsigned WIDTH_DEFAULT = 8;
   localparam int unsigned SLICE_BITS    = 2;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Slice counter width; at least one bit even when only two slices exist.
   function automatic int unsigned idx_width(input int unsigned width);
      int unsigned num_slices;
      num_slices = width / SLICE_BITS;
      return (num_slices <= 2) ? 1 : $clog2(num_slices);
   endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if
// Request/result bundle for the serial adder controller.
//   start      - request to begin an addition
//   a, b, ci   - operands and carry-in, captured with start
//   sum, co    - result and carry-out, valid while done is high and held afterwards
//   busy, done - addition in progress / single-cycle completion pulse
// Modports: master drives the request side, slave is the controller.
interface serial_add_ctrl_if
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic [WIDTH-1:0] sum;
   logic             co;
   logic             busy;
   logic             done;

   modport master (
      output start, a, b, ci,
      input  sum, co, busy, done
   );

   modport slave (
      input  start, a, b, ci,
      output sum, co, busy, done
   );

endinterface

// File: rtl/carry_adder.sv
// carry_adder
// Two-bit ripple-carry adder slice.
//   a, b - 2-bit addends
//   ci   - carry-in
//   sum  - 2-bit sum
//   co   - carry-out of bit 1
module carry_adder (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       ci,
   output logic [1:0] sum,
   output logic       co
);

   logic c1;

   always_comb begin
      sum[0] = a[0] ^ b[0] ^ ci;
      c1     = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
      sum[1] = a[1] ^ b[1] ^ c1;
      co     = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
   end

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Adds two WIDTH-bit operands two bits per cycle through a single carry_adder slice.
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - serial_add_ctrl_if slave: start/a/b/ci in, sum/co/busy/done out
// start is accepted in idle or done; WIDTH/2 run cycles follow, then a one-cycle done.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT,
   parameter int unsigned SLICE = SLICE_BITS
) (
   input  logic              clk,
   input  logic              rst,
   serial_add_ctrl_if.slave  bus
);

   localparam int unsigned NUM_SLICES = WIDTH / SLICE;
   localparam int unsigned IDX_W      = idx_width(WIDTH);
   localparam int unsigned POS_W      = $clog2(WIDTH);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             co_q, co_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic [POS_W-1:0] bit_pos;
   logic [SLICE-1:0] slice_sum;
   logic             slice_co;

   // Lowest bit position of the slice being added this cycle.
   assign bit_pos = POS_W'(idx_q * SLICE);

   carry_adder u_carry_adder (
      .a   (a_q[bit_pos +: SLICE]),
      .b   (b_q[bit_pos +: SLICE]),
      .ci  (carry_q),
      .sum (slice_sum),
      .co  (slice_co)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      co_d    = co_q;
      idx_d   = idx_q;

      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (bus.start) begin
               state_d = StRun;
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.ci;
               sum_d   = '0;
               co_d    = 1'b0;
               idx_d   = '0;
            end
         end
         StRun: begin
            sum_d[bit_pos +: SLICE] = slice_sum;
            carry_d                 = slice_co;
            idx_d                   = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               // Top-slice carry goes to co only; sum wraps modulo 2^WIDTH.
               state_d = StDone;
               co_d    = slice_co;
               idx_d   = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         co_q    <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         co_q    <= co_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.sum  = sum_q;
   assign bus.co   = co_q;
   assign bus.busy = (state_q == StRun);
   assign bus.done = (state_q == StDone);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
// Directed bench for serial_add_ctrl at WIDTH=8 with hand-computed results.
module tb_serial_add_ctrl;
   import serial_add_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   int   done_cnt;

   serial_add_ctrl_if #(.WIDTH(8)) bus ();

   serial_add_ctrl #(.WIDTH(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts every cycle in which done is seen high.
   always @(negedge clk) begin
      if (bus.done === 1'b1) done_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns on the negedge just after the accepting edge E0.
   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic ci);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.ci    = ci;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Number of rising edges until done is seen; 0 if it never comes.
   task automatic wait_done(output int lat);
      lat = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic [7:0] exp_sum, input logic exp_co);
      int lat;
      start_op(a, b, ci);
      check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
      check_eq({tag, "_clr"}, 32'(bus.sum), 32'h00);
      wait_done(lat);
      check_eq({tag, "_lat"}, 32'(lat), 32'd4);
      check_eq({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
      check_eq({tag, "_co"}, 32'(bus.co), 32'(exp_co));
      @(negedge clk);
      check_eq({tag, "_pulse"}, 32'(bus.done), 32'd0);
      check_eq({tag, "_idle"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int lat;
      int d0;
      n_checks  = 0;
      n_fail    = 0;
      done_cnt  = 0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.ci    = 1'b0;
      rst       = 1'b1;

      // Start held high during reset must be ignored.
      bus.start = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_done", 32'(bus.done), 32'd0);
      check_eq("rst_sum", 32'(bus.sum), 32'h00);
      check_eq("rst_co", 32'(bus.co), 32'd0);
      bus.start = 1'b0;
      rst       = 1'b0;

      run_add("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      run_add("small", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
      run_add("ffff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);

      // Result holds while idle.
      repeat (3) @(negedge clk);
      check_eq("hold_sum", 32'(bus.sum), 32'hFE);
      check_eq("hold_co", 32'(bus.co), 32'd1);

      run_add("prop", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);

      // start pulsed during RUN is ignored.
      d0 = done_cnt;
      start_op(8'h10, 8'h20, 1'b0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'hFF;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = 8'h00;
      wait_done(lat);
      check_eq("ign_lat", 32'(lat), 32'd2);
      check_eq("ign_sum", 32'(bus.sum), 32'h30);
      repeat (3) @(negedge clk);
      check_eq("ign_pulses", 32'(done_cnt - d0), 32'd1);
      check_eq("ign_idle", 32'(bus.busy), 32'd0);

      // Reset two cycles into RUN aborts immediately.
      start_op(8'h55, 8'h55, 1'b0);
      repeat (2) @(negedge clk);
      check_eq("abort_part", 32'(bus.sum), 32'h0A);
      d0 = done_cnt;
      #1 rst = 1'b1;
      #1;
      check_eq("abort_busy", 32'(bus.busy), 32'd0);
      check_eq("abort_sum", 32'(bus.sum), 32'h00);
      check_eq("abort_done", 32'(bus.done), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("abort_nodone", 32'(done_cnt - d0), 32'd0);
      run_add("fresh", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);

      // Back-to-back: start held high in DONE.
      start_op(8'h11, 8'h22, 1'b0);
      wait_done(lat);
      check_eq("b2b1_lat", 32'(lat), 32'd4);
      check_eq("b2b1_sum", 32'(bus.sum), 32'h33);
      bus.start = 1'b1;
      bus.a     = 8'h0F;
      bus.b     = 8'h01;
      bus.ci    = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      check_eq("b2b_nogap", 32'(bus.busy), 32'd1);
      check_eq("b2b_clr", 32'(bus.sum), 32'h00);
      wait_done(lat);
      check_eq("b2b2_lat", 32'(lat), 32'd4);
      check_eq("b2b2_sum", 32'(bus.sum), 32'h10);
      check_eq("b2b2_co", 32'(bus.co), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
